// File: rtl/dot_reader_pkg.sv
// Shared types for the dual-FIFO dot-product reader.
package dot_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_dot_reader_mac.sv
// Multiply-accumulate stage: accumulates a*b one cycle after each read enable,
// matching the FIFOs' registered read data.
module dot_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    // Wide enough for both the full product and the accumulator; the sum is
    // truncated back to ACC_WIDTH so accumulation wraps.
    localparam int SUM_WIDTH  = (ACC_WIDTH > PROD_WIDTH) ? ACC_WIDTH : PROD_WIDTH;

    logic                 pend_reg;
    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [SUM_WIDTH-1:0] prod_ext;
    logic [SUM_WIDTH-1:0] sum_ext;

    always_comb begin
        prod_ext = SUM_WIDTH'(a) * SUM_WIDTH'(b);
        sum_ext  = SUM_WIDTH'(acc_reg) + prod_ext;
        acc_next = sum_ext[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg <= 1'b0;
            acc_reg  <= '0;
        end else begin
            pend_reg <= en;
            if (clr) begin
                acc_reg <= '0;
            end else if (pend_reg) begin
                acc_reg <= acc_next;
            end
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/fifo_dot_reader.sv
// Drains LEN operand pairs from two FIFOs in lockstep and reports their
// unsigned dot product with a one-cycle result_valid pulse.
module fifo_dot_reader
    import dot_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN        = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_rden,
    output logic                  b_rden,
    output logic                  busy,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid
);

    localparam int CNT_WIDTH = $clog2(LEN + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(LEN - 1);

    rd_state_t            state_reg;
    rd_state_t            state_next;
    logic [CNT_WIDTH-1:0] issued_reg;
    logic [CNT_WIDTH-1:0] issued_next;
    logic                 fire;
    logic                 clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            issued_reg <= '0;
        end else begin
            state_reg  <= state_next;
            issued_reg <= issued_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        issued_next  = issued_reg;
        fire         = 1'b0;
        clr          = 1'b0;
        a_rden       = 1'b0;
        b_rden       = 1'b0;
        busy         = (state_reg != IDLE);
        result_valid = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    clr         = 1'b1;
                    issued_next = '0;
                    state_next  = READ;
                end
            end
            READ: begin
                // No lookahead: a pair is taken only when both sides are non-empty now.
                fire = !a_empty && !b_empty;
                if (fire) begin
                    a_rden      = 1'b1;
                    b_rden      = 1'b1;
                    issued_next = issued_reg + 1'b1;
                    if (issued_reg == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    dot_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (fire),
        .a   (a_data),
        .b   (b_data),
        .acc (result)
    );

endmodule
